// File: rtl/ppe_pkg.sv
// Shared PPE/NoC packet definitions: field positions, destination IDs and opcodes.
// Packet layout is dest[29:26] | opcode[25] | data[24:0].
package ppe_pkg;

   localparam int PKT_W      = 30;
   localparam int ADDR_START = 29;
   localparam int ADDR_END   = 26;
   localparam int OPCODE     = 25;
   localparam int DATA_START = 24;
   localparam int DATA_END   = 0;

   localparam int IMEM_ID    = 10;

   localparam logic OP_WEIGHT = 1'b0;
   localparam logic OP_INPUT  = 1'b1;

   typedef struct packed {
      logic [ADDR_START-ADDR_END:0]  dest;
      logic                          opcode;
      logic [DATA_START-DATA_END:0]  data;
   } packet_t;

endpackage

// File: rtl/ppe_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching from
// last_grant+1 upward, wrapping modulo N.
module ppe_rr_pick #(
   parameter  int N  = 5,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_grant,
   output logic          found,
   output logic [IW-1:0] grant
);

   logic [IW-1:0] idx;

   always_comb begin
      found = 1'b0;
      grant = '0;
      idx   = '0;
      // k = N revisits last_grant itself, so a lone requester keeps winning
      for (int k = 1; k <= N; k++) begin
         idx = IW'((int'(last_grant) + k) % N);
         if (!found && req[idx]) begin
            found = 1'b1;
            grant = idx;
         end
      end
   end

endmodule

// File: rtl/ppe_out_arbiter.sv
// Round-robin arbiter sharing one NoC output link among N_REQ PPEs, with a
// single-entry output register, I_MEM flag and forwarded-packet counter.
module ppe_out_arbiter #(
   parameter  int N_REQ   = 5,
   parameter  int PKT_W   = 30,
   parameter  int IMEM_ID = 10,
   parameter  int CNT_W   = 16,
   localparam int IW      = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*PKT_W-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   out_valid,
   output logic [PKT_W-1:0]       out_data,
   input  logic                   out_ready,
   output logic                   out_is_imem,
   output logic [IW-1:0]          last_grant,
   output logic [CNT_W-1:0]       fwd_count
);

   import ppe_pkg::*;

   localparam int DEST_W = ADDR_START - ADDR_END + 1;

   logic [N_REQ-1:0][PKT_W-1:0] req_pkt;
   logic                        found;
   logic [IW-1:0]               grant;
   logic                        slot_free;
   logic                        fire;
   logic [PKT_W-1:0]            win_pkt;

   assign req_pkt = req_data;

   ppe_rr_pick #(.N(N_REQ)) u_pick (
      .req        (req_valid),
      .last_grant (last_grant),
      .found      (found),
      .grant      (grant)
   );

   // Drain and refill may happen on the same edge.
   assign slot_free = !out_valid || out_ready;
   // rst_n gating keeps req_ready low while the register is held in reset.
   assign fire      = found && slot_free && rst_n;
   assign win_pkt   = req_pkt[grant];

   always_comb begin
      req_ready = '0;
      if (fire)
         req_ready[grant] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_is_imem <= 1'b0;
         last_grant  <= IW'(N_REQ - 1);
         fwd_count   <= '0;
      end else if (fire) begin
         out_valid   <= 1'b1;
         out_data    <= win_pkt;
         out_is_imem <= (win_pkt[ADDR_START:ADDR_END] == DEST_W'(IMEM_ID));
         last_grant  <= grant;
         fwd_count   <= fwd_count + CNT_W'(1);
      end else if (out_ready) begin
         out_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ppe_out_arbiter.sv
// Randomized + directed bench for ppe_out_arbiter: integer-level arbitration
// model, expected-packet queue and an independent output monitor.
module tb_ppe_out_arbiter;
   import ppe_pkg::*;

   localparam int N  = 5;
   localparam int W  = 30;
   localparam int CW = 16;
   localparam int IW = 3;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic           out_ready = 1'b0;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_data;
   logic           out_valid;
   logic           out_is_imem;
   logic [W-1:0]   out_data;
   logic [IW-1:0]  last_grant;
   logic [CW-1:0]  fwd_count;

   logic [N-1:0]   src_valid = '0;
   logic [W-1:0]   src_data [N];
   int             gen_pct [N];
   int             rdy_pct = 100;

   int passed = 0;
   int total  = 0;

   typedef struct packed {
      logic [W-1:0] d;
      logic         imem;
   } exp_t;
   exp_t sbq[$];

   int m_last;
   int m_cnt;
   bit m_ov;

   always #5 clk = ~clk;

   assign req_valid = src_valid;
   always_comb begin
      req_data = '0;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = src_data[i];
   end

   ppe_out_arbiter #(.N_REQ(N), .PKT_W(W), .IMEM_ID(10), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .out_is_imem (out_is_imem),
      .last_grant  (last_grant),
      .fwd_count   (fwd_count)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h @%0t", nm, act, exp, $time);
   endtask

   function automatic logic [W-1:0] rand_pkt();
      packet_t p;
      int s;
      s = int'($urandom_range(5));
      p.dest   = (s == 5) ? 4'd10 : 4'(s);
      p.opcode = 1'($urandom);
      p.data   = 25'($urandom);
      return p;
   endfunction

   // Reference: whoever is next after the previous winner, cyclically, wins
   // when the output slot is empty or being emptied this cycle.
   always @(negedge clk) begin : model
      int           g;
      bit           free;
      logic [N-1:0] er;
      exp_t         e;
      if (!rst_n) begin
         m_last = N - 1;
         m_ov   = 0;
         m_cnt  = 0;
         chk("rst_req_ready", req_ready, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_fwd_count", fwd_count, 0);
         chk("rst_last_grant", last_grant, N - 1);
      end else begin
         free = !m_ov || (out_ready === 1'b1);
         g = -1;
         for (int k = 1; k <= N; k++)
            if (g < 0 && src_valid[(m_last + k) % N]) g = (m_last + k) % N;
         er = '0;
         if (g >= 0 && free) er = N'(1) << g;
         chk("req_ready", req_ready, er);
         chk("out_valid", out_valid, m_ov);
         chk("last_grant", last_grant, m_last);
         chk("fwd_count", fwd_count, m_cnt);
         if (g >= 0 && free) begin
            e.d    = src_data[g];
            e.imem = (src_data[g][29:26] == 4'd10);
            sbq.push_back(e);
            m_last = g;
            m_cnt  = (m_cnt + 1) % 65536;
            m_ov   = 1;
         end else if (m_ov && out_ready === 1'b1) begin
            m_ov = 0;
         end
      end
   end

   always @(negedge clk) begin : monitor
      if (rst_n && out_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            total++;
            $display("FAIL sb_empty: got out_valid=1 with data 0x%0h, want no packet @%0t", out_data, $time);
         end else begin
            chk("out_data", out_data, sbq[0].d);
            chk("out_is_imem", out_is_imem, sbq[0].imem);
            if (out_ready === 1'b1) void'(sbq.pop_front());
         end
      end
   end

   task automatic step();
      logic [N-1:0] hs;
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (hs[i]) src_valid[i] = 1'b0;
         if (!src_valid[i] && int'($urandom_range(99)) < gen_pct[i]) begin
            src_valid[i] = 1'b1;
            src_data[i]  = rand_pkt();
         end
      end
      out_ready = (int'($urandom_range(99)) < rdy_pct);
      #1;
   endtask

   task automatic do_reset();
      #1 rst_n = 1'b0;
      src_valid = '0;
      sbq.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish, want finish before 5ms");
      $fatal(1, "timeout");
   end

   initial begin
      logic [W-1:0] held;
      for (int i = 0; i < N; i++) begin
         src_data[i] = '0;
         gen_pct[i]  = 0;
      end
      out_ready = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // lone requester 0 straight out of reset
      src_data[0]  = 30'h0400_0007;
      src_valid[0] = 1'b1;
      rst_n        = 1'b1;
      step();
      chk("t1_out_valid", out_valid, 1);
      chk("t1_out_data", out_data, 30'h0400_0007);
      chk("t1_fwd_count", fwd_count, 1);
      chk("t1_last_grant", last_grant, 0);

      // all requesting: strict rotation, one per cycle
      do_reset();
      for (int i = 0; i < N; i++) begin
         gen_pct[i]   = 100;
         src_valid[i] = 1'b1;
         src_data[i]  = rand_pkt();
      end
      for (int k = 0; k < 7; k++) begin
         step();
         chk("t2_grant_order", last_grant, k % N);
         chk("t2_out_valid", out_valid, 1);
      end
      chk("t2_fwd_count", fwd_count, 7);

      // backpressure hold, then drain+refill on one edge
      rdy_pct   = 0;
      out_ready = 1'b0;
      held      = out_data;
      repeat (4) begin
         step();
         chk("t3_hold_data", out_data, held);
         chk("t3_hold_ready", req_ready, 0);
         chk("t3_hold_valid", out_valid, 1);
      end
      rdy_pct   = 100;
      out_ready = 1'b1;
      step();
      chk("t3_refill_fwd", fwd_count, 8);
      chk("t3_refill_grant", last_grant, 2);
      chk("t3_refill_valid", out_valid, 1);

      // I_MEM flag
      for (int i = 0; i < N; i++) gen_pct[i] = 0;
      repeat (6) step();
      src_data[3]  = 30'h2800_0000;
      src_valid[3] = 1'b1;
      step();
      chk("t4_imem_valid", out_valid, 1);
      chk("t4_imem_data", out_data, 30'h2800_0000);
      chk("t4_imem_flag", out_is_imem, 1);
      src_data[3]  = 30'h0800_0000;
      src_valid[3] = 1'b1;
      step();
      chk("t4_spe_data", out_data, 30'h0800_0000);
      chk("t4_spe_flag", out_is_imem, 0);

      // asynchronous reset mid-cycle with a packet held
      for (int i = 0; i < N; i++) gen_pct[i] = 100;
      step();
      step();
      #1 rst_n = 1'b0;
      #1;
      chk("t5_async_valid", out_valid, 0);
      chk("t5_async_fwd", fwd_count, 0);
      chk("t5_async_ready", req_ready, 0);
      chk("t5_async_grant", last_grant, N - 1);
      sbq.delete();
      for (int i = 0; i < N; i++) gen_pct[i] = 0;
      src_valid    = '0;
      src_data[0]  = 30'h0C00_0011;
      src_data[4]  = 30'h1000_0044;
      src_valid[0] = 1'b1;
      src_valid[4] = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      chk("t5_first_grant", last_grant, 0);
      chk("t5_first_data", out_data, 30'h0C00_0011);
      step();
      chk("t5_second_grant", last_grant, 4);
      chk("t5_second_data", out_data, 30'h1000_0044);

      // counter wrap with a single requester
      do_reset();
      src_valid[2] = 1'b1;
      src_data[2]  = rand_pkt();
      gen_pct[2]   = 100;
      repeat (65535) step();
      chk("t6_fwd_max", fwd_count, 16'hFFFF);
      chk("t6_single_grant", last_grant, 2);
      step();
      chk("t6_fwd_wrap", fwd_count, 0);
      chk("t6_wrap_valid", out_valid, 1);
      chk("t6_wrap_grant", last_grant, 2);
      for (int i = 0; i < N; i++) gen_pct[i] = 100;
      repeat (20) step();

      // randomized traffic and backpressure
      do_reset();
      for (int i = 0; i < N; i++) gen_pct[i] = int'($urandom_range(90, 20));
      rdy_pct = 70;
      repeat (2000) step();

      // drain
      for (int i = 0; i < N; i++) gen_pct[i] = 0;
      rdy_pct   = 100;
      out_ready = 1'b1;
      repeat (12) step();
      chk("drain_queue", sbq.size(), 0);
      chk("drain_valid", out_valid, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ppe_out_arbiter.md
Name: ppe_out_arbiter

Overview:
Clocked round-robin arbiter that shares one NoC output link among N_REQ partial-sum PEs (PPEs). Each PPE presents 30-bit packets, either partial sums bound for SPEs 0-4 or input requests bound to I_MEM (ID 10). The arbiter grants one requester per cycle into a single-entry output register and forwards it over a valid/ready link to the router. It also flags I_MEM requests and keeps a forwarded-packet count for debug.

Parameters:
N_REQ, 5, number of PPE requesters (2..8)
PKT_W, 30, packet width: [29:26] dest, [25] opcode, [24:0] data
IMEM_ID, 10, destination address of I_MEM
CNT_W, 16, width of forwarded-packet counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  per-PPE packet valid
req_data  in  N_REQ*PKT_W  per-PPE packet; slice i = [i*PKT_W +: PKT_W]
req_ready  out  N_REQ  per-PPE accept (one-hot or zero)
out_valid  out  1  output packet valid
out_data  out  PKT_W  output packet
out_ready  in  1  downstream accept
out_is_imem  out  1  registered; out_data[29:26]==IMEM_ID
last_grant  out  $clog2(N_REQ)  index of most recent grant
fwd_count  out  CNT_W  packets accepted since reset, wraps

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_is_imem=0, fwd_count=0.
  - last_grant=N_REQ-1, so requester 0 has first priority.
  - Any held packet is discarded.
  - req_ready=0 while rst_n=0.
- Slot free: slot_free = !out_valid | out_ready (drain and refill in the same cycle are allowed).
- Arbitration (combinational):
  - Among i with req_valid[i]=1, pick the first found searching last_grant+1, +2, ... modulo N_REQ.
  - req_ready[g]=1 only if a winner g exists and slot_free=1; all other req_ready bits are 0.
  - req_ready never asserts for a requester with req_valid=0.
- Transfer (rising edge with req_valid[g] & req_ready[g]):
  - out_data<=req_data[g], out_valid<=1, out_is_imem<=(dest==IMEM_ID).
  - last_grant<=g; fwd_count<=fwd_count+1, wrapping from 2^CNT_W-1 to 0.
- Drain without refill: out_valid & out_ready & no grant -> out_valid<=0; out_data keeps its last value.
- Hold: while out_valid & !out_ready, out_data and out_is_imem are stable and all req_ready=0.
- Latency and throughput:
  - Packet appears on out_valid the cycle after acceptance.
  - Sustained throughput is 1 packet/cycle with out_ready=1.
- Requester protocol: once req_valid asserts, req_data must stay stable until req_ready. The arbiter does not check this.
- Fairness: a continuously requesting PPE waits at most N_REQ-1 grants.
- Single requester: granted every cycle the slot is free; last_grant stays at that index.
- Lone requester index 0 after reset: granted immediately.
- No packet modification: opcode and data pass through bit-exact.
- Reset mid-transfer: the packet in the output register is lost. The sending PPE already saw req_ready, so upper layers must resend.

Decomposition:
- Package ppe_pkg holds:
  - field constants ADDR_START=29, ADDR_END=26, OPCODE=25, DATA_START=24, DATA_END=0;
  - PKT_W, IMEM_ID, opcode constants OP_WEIGHT=0, OP_INPUT=1;
  - typedef packet_t (packed struct: dest[3:0], opcode, data[24:0]).
- Sub-module ppe_rr_pick: purely combinational rotate/priority picker.
  - Inputs: req vector, last_grant.
  - Outputs: found, grant index.
  - Reusable by the SPE-side input scheduler.

Test Plan:
1. Reset release, req_valid=5'b00001, req_data[0]=0x0400_0007 (dest 1), out_ready=1 -> req_ready[0] high cycle 0; out_valid=1, out_data=0x0400_0007 next cycle; fwd_count=1; last_grant=0.
2. All 5 valid continuously, out_ready=1 -> grant order 0,1,2,3,4,0,1; one packet/cycle; fwd_count=7 after 7 cycles.
3. out_ready=0 for 4 cycles with out_valid=1 -> out_data stable and req_ready=5'b00000 throughout. When out_ready rises, drain and the next grant occur in the same cycle, with no bubble.
4. Requester 3 sends dest=10 (0x2800_0000) -> out_is_imem=1 alongside out_valid. A following dest=2 packet -> out_is_imem=0.
5. rst_n pulled low asynchronously mid-cycle while out_valid=1 -> out_valid=0 immediately (before the next edge), fwd_count=0. After release, requester 0 wins over 4 when both are valid.
6. Preload fwd_count by 65535 transfers, then one more -> fwd_count wraps to 0; arbitration unaffected.
